ysyx_23060221_ifu: RTL

YSYX_23060221_IFU -- requirements
Module: ysyx_23060221_ifu

---
 rtl/ysyx_23060221_pkg.sv | 38 +++
 rtl/ysyx_23060221_ifu_fsm.sv | 111 +++++++++++
 rtl/ysyx_23060221_ifu.sv | 107 ++++++++++
 3 files changed

// File: rtl/ysyx_23060221_pkg.sv
// Shared definitions for the ysyx_23060221 instruction fetch unit.
// Holds the fetch FSM state enum, reset PC default, the NOP encoding used
// while no real instruction has been fetched, the bus OKAY response code,
// the packed fetch-result payload and small address helpers.
package ysyx_23060221_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RESP_W = 2;

    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0]   INST_NOP         = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [RESP_W-1:0] RESP_OKAY        = 2'b00;

    // Fetch sequencing: request -> response -> present to decode -> wait for next PC
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_OUT  = 2'd2,
        S_WAIT = 2'd3
    } ifu_state_e;

    // Instruction word handed to decode together with its fault flag
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic            fault;
    } fetch_pkt_t;

    // True when the two low PC bits make the address non-word-aligned
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

    // Word-aligned bus address for a PC
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ysyx_23060221_ifu_fsm.sv
// Fetch control FSM for the ysyx_23060221 IFU.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   arready, rvalid     read-address / read-data channel handshakes from the bus
//   idu_ready           decode stage accepts the presented instruction
//   npc_valid           next-PC pulse from writeback
//   misalign_pc         current PC is misaligned (tied low when alignment checking is off)
//   misalign_npc        incoming npc is misaligned (tied low when alignment checking is off)
//   arvalid, rready,
//   ifu_valid           registered handshake outputs
//   resp_take_c         this cycle latches read data into the instruction register
//   misalign_take_c     this cycle skips the bus and presents a faulting NOP
//   npc_take_c          this cycle loads npc into the PC
module ysyx_23060221_ifu_fsm
    import ysyx_23060221_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic arready,
    input  logic rvalid,
    input  logic idu_ready,
    input  logic npc_valid,
    input  logic misalign_pc,
    input  logic misalign_npc,
    output logic arvalid,
    output logic rready,
    output logic ifu_valid,
    output logic resp_take_c,
    output logic misalign_take_c,
    output logic npc_take_c
);

    ifu_state_e state_q, state_d;
    logic       arvalid_q, arvalid_d;
    logic       rready_q, rready_d;
    logic       ifu_valid_q, ifu_valid_d;
    logic       next_pc_misaligned;

    // Next-state, transfer strobes and next values of the registered outputs
    always_comb begin
        state_d         = state_q;
        resp_take_c     = 1'b0;
        misalign_take_c = 1'b0;
        npc_take_c      = 1'b0;

        unique case (state_q)
            S_REQ: begin
                // npc_valid is deliberately ignored while a fetch is in flight
                if (misalign_pc) begin
                    state_d         = S_OUT;
                    misalign_take_c = 1'b1;
                end else if (arvalid_q && arready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rvalid) begin
                    state_d     = S_OUT;
                    resp_take_c = 1'b1;
                end
            end
            S_OUT: begin
                // A next PC arriving with the decode handshake skips S_WAIT
                if (ifu_valid_q && idu_ready) begin
                    if (npc_valid) begin
                        state_d    = S_REQ;
                        npc_take_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (npc_valid) begin
                    state_d    = S_REQ;
                    npc_take_c = 1'b1;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Entering S_REQ from elsewhere always comes with a freshly loaded npc
        next_pc_misaligned = (state_q == S_REQ) ? misalign_pc : misalign_npc;

        arvalid_d   = (state_d == S_REQ) && !next_pc_misaligned;
        rready_d    = (state_d == S_RESP);
        ifu_valid_d = (state_d == S_OUT);
    end

    // State and handshake output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ifu_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            ifu_valid_q <= ifu_valid_d;
        end
    end

    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign ifu_valid = ifu_valid_q;

endmodule

// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch unit: issues one word read per PC, holds the returned
// instruction for the decode stage, then waits for writeback to supply the
// next PC. No internal PC increment.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   araddr/arvalid/arready          read-address channel
//   rdata/rresp/rvalid/rready       read-data channel (rresp != OKAY marks a bad fetch)
//   inst/pc/fetch_fault/IFU_valid   instruction presented to decode
//   IDU_ready                       decode accepts the instruction
//   npc/npc_valid                   next PC from writeback (single-cycle pulse)
// Build option:
//   YSYX_23060221_IFU_ALIGN_CHECK_EN  misaligned PCs skip the bus and present a faulting NOP;
//                                     when undefined the low PC bits are dropped from araddr.
module ysyx_23060221_ifu
    import ysyx_23060221_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        IFU_valid,
    input  logic        IDU_ready,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic        fetch_fault
);

    logic [XLEN-1:0] pc_q, pc_d;
    fetch_pkt_t      pkt_q, pkt_d;

    logic resp_take_c;
    logic misalign_take_c;
    logic npc_take_c;
    logic misalign_pc;
    logic misalign_npc;

`ifdef YSYX_23060221_IFU_ALIGN_CHECK_EN
    assign misalign_pc  = pc_misaligned(pc_q[1:0]);
    assign misalign_npc = pc_misaligned(npc[1:0]);
`else
    assign misalign_pc  = 1'b0;
    assign misalign_npc = 1'b0;
`endif

    ysyx_23060221_ifu_fsm u_fsm (
        .clk             (clk),
        .rst_n           (rst_n),
        .arready         (arready),
        .rvalid          (rvalid),
        .idu_ready       (IDU_ready),
        .npc_valid       (npc_valid),
        .misalign_pc     (misalign_pc),
        .misalign_npc    (misalign_npc),
        .arvalid         (arvalid),
        .rready          (rready),
        .ifu_valid       (IFU_valid),
        .resp_take_c     (resp_take_c),
        .misalign_take_c (misalign_take_c),
        .npc_take_c      (npc_take_c)
    );

    // PC and fetched-instruction next values
    always_comb begin
        pc_d  = pc_q;
        pkt_d = pkt_q;

        if (npc_take_c) begin
            pc_d = npc;
        end

        if (resp_take_c) begin
            pkt_d.inst  = rdata;
            pkt_d.fault = (rresp != RESP_OKAY);
        end else if (misalign_take_c) begin
            pkt_d.inst  = INST_NOP;
            pkt_d.fault = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pkt_q.inst  <= INST_NOP;
            pkt_q.fault <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            pkt_q <= pkt_d;
        end
    end

    // Only issued when aligned under the alignment check, so masking is harmless there
    assign araddr      = word_addr(pc_q);
    assign pc          = pc_q;
    assign inst        = pkt_q.inst;
    assign fetch_fault = pkt_q.fault;

endmodule
